// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: stage enables, flush/bubble
// controls, memory-wait timeout tracking and saturating stall/flush performance counters.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  RUN      | normal flow; hazards resolved combinationally each cycle
//  MEM_WAIT | data memory is holding the pipeline; wait counter running

module hazard_stall_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             perf_clr,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pc_sel,
   output logic             mem_timeout,
   output logic [WIDTH-1:0] stall_cycles,
   output logic [WIDTH-1:0] flush_count
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   state_t      state, state_nxt;
   logic [15:0] wait_cnt;
   logic        mem_stall, load_use, br_flush;
   logic        pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c;
   logic        if_id_flush_c, id_ex_flush_c, pc_sel_c;

   always_comb begin
      mem_stall     = mem_req & ~mem_ready;
      load_use      = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
      pc_en_c       = 1'b1;
      if_id_en_c    = 1'b1;
      id_ex_en_c    = 1'b1;
      ex_mem_en_c   = 1'b1;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      pc_sel_c      = 1'b0;
      br_flush      = 1'b0;
      if (mem_stall) begin
         // frozen EX re-presents any branch or load-use once memory completes
         pc_en_c     = 1'b0;
         if_id_en_c  = 1'b0;
         id_ex_en_c  = 1'b0;
         ex_mem_en_c = 1'b0;
      end else if (ex_branch_taken) begin
         pc_sel_c      = 1'b1;
         if_id_flush_c = 1'b1;
         id_ex_flush_c = 1'b1;
         br_flush      = 1'b1;
      end else if (load_use) begin
         pc_en_c       = 1'b0;
         if_id_en_c    = 1'b0;
         id_ex_flush_c = 1'b1;
      end
   end

   assign pc_en       = pc_en_c       & reset_n;
   assign if_id_en    = if_id_en_c    & reset_n;
   assign id_ex_en    = id_ex_en_c    & reset_n;
   assign ex_mem_en   = ex_mem_en_c   & reset_n;
   assign if_id_flush = if_id_flush_c & reset_n;
   assign id_ex_flush = id_ex_flush_c & reset_n;
   assign pc_sel      = pc_sel_c      & reset_n;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (mem_stall) state_nxt = MEM_WAIT;
         MEM_WAIT: if (!mem_stall) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RUN;
      else          state <= state_nxt;
   end

   // counter parks at TIMEOUT; the stall itself is never forced to complete
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 16'd0;
      end else if (state == RUN) begin
         wait_cnt <= 16'd0;
      end else if (mem_stall && (wait_cnt != TIMEOUT_W)) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_timeout <= 1'b0;
      end else if (perf_clr) begin
         mem_timeout <= 1'b0;
      end else if ((state == MEM_WAIT) && mem_stall && (wait_cnt == TIMEOUT_W - 16'd1)) begin
         mem_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else if (perf_clr) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_en_c && (stall_cycles != '1)) stall_cycles <= stall_cycles + WIDTH'(1);
         if (br_flush && (flush_count != '1))  flush_count  <= flush_count + WIDTH'(1);
      end
   end

endmodule
